// File: rtl/pipe_pkg.sv
// Shared types and width constants for the pipeline stage register family.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

    localparam int PIPE_DATA_W = 32;
    localparam int PIPE_CTL_W  = 16;
    localparam int PIPE_PERF_W = 32;

endpackage

// File: rtl/pipe_stage_ctrl.sv
// Handshake / occupancy state machine for pipe_stage_reg; steers the payload
// registers through load_main, load_skid and skid_to_main.
module pipe_stage_ctrl
    import pipe_pkg::*;
#(
    parameter int SKID = 1
) (
    input  logic       clock,
    input  logic       nreset,
    input  logic       flush,
    input  logic       in_valid,
    input  logic       out_ready,
    output logic       in_ready,
    output logic       out_valid,
    output logic       load_main,
    output logic       load_skid,
    output logic       skid_to_main,
    output logic [1:0] occupancy
);

    pipe_state_e state_q, state_d;
    logic        in_fire;
    logic        out_fire;

    assign out_valid = (state_q != EMPTY);
    assign out_fire  = out_valid && out_ready;
    assign in_fire   = in_valid && in_ready;
    assign occupancy = state_q;

    // NOTE: reset is sampled on the clock edge (synchronous), so it lives inside the if/else of the clocked block.
    always_ff @(posedge clock) begin
        if (!nreset) state_q <= EMPTY;
        else         state_q <= state_d;
    end

    if (SKID != 0) begin : g_skid
        logic in_ready_q;

        // Registered ready: it looks one state ahead so FULL is never overrun.
        always_ff @(posedge clock) begin
            if (!nreset) in_ready_q <= 1'b1;
            else         in_ready_q <= (state_d != FULL);
        end

        assign in_ready = in_ready_q;

        always_comb begin
            // NOTE: every output gets a default first so no path can infer a latch.
            state_d      = state_q;
            load_main    = 1'b0;
            load_skid    = 1'b0;
            skid_to_main = 1'b0;
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        load_main = 1'b1;
                        state_d   = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        load_main = 1'b1;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end else if (in_fire) begin
                        load_skid = 1'b1;
                        state_d   = FULL;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        skid_to_main = 1'b1;
                        state_d      = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
            // Flush drops any accepted input and leaves the payload untouched.
            if (flush) begin
                state_d      = EMPTY;
                load_main    = 1'b0;
                load_skid    = 1'b0;
                skid_to_main = 1'b0;
            end
        end
    end else begin : g_single
        assign in_ready = !out_valid || out_ready;

        always_comb begin
            state_d      = state_q;
            load_main    = 1'b0;
            load_skid    = 1'b0;
            skid_to_main = 1'b0;
            if (in_fire) begin
                load_main = 1'b1;
                state_d   = ONE;
            end else if (out_fire) begin
                state_d = EMPTY;
            end
            if (flush) begin
                state_d   = EMPTY;
                load_main = 1'b0;
            end
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised valid/ready pipeline stage with optional skid entry and bubble ctl masking.
// Define PIPE_STAGE_PERF_EN to add saturating stall_cycles / bubble_cycles counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W        = PIPE_DATA_W,
    parameter int CTL_W         = PIPE_CTL_W,
    parameter int SKID          = 1,
    parameter int DATA_RST_ZERO = 1
) (
    input  logic              clock,
    input  logic              nreset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTL_W-1:0]  in_ctl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTL_W-1:0]  out_ctl,
    output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [PIPE_PERF_W-1:0] stall_cycles,
    output logic [PIPE_PERF_W-1:0] bubble_cycles
`endif
);

    logic load_main;
    logic load_skid;
    logic skid_to_main;

    pipe_stage_ctrl #(
        .SKID(SKID)
    ) u_ctrl (
        .clock       (clock),
        .nreset      (nreset),
        .flush       (flush),
        .in_valid    (in_valid),
        .out_ready   (out_ready),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .load_main   (load_main),
        .load_skid   (load_skid),
        .skid_to_main(skid_to_main),
        .occupancy   (occupancy)
    );

    logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic [CTL_W-1:0]  main_ctl_q, main_ctl_d, skid_ctl_q, skid_ctl_d;

    always_comb begin
        main_data_d = main_data_q;
        main_ctl_d  = main_ctl_q;
        if (load_main) begin
            main_data_d = in_data;
            main_ctl_d  = in_ctl;
        end else if (skid_to_main) begin
            main_data_d = skid_data_q;
            main_ctl_d  = skid_ctl_q;
        end
        skid_data_d = load_skid ? in_data : skid_data_q;
        skid_ctl_d  = load_skid ? in_ctl  : skid_ctl_q;
    end

    // Control bits always reset so a stray enable can never leak out of reset.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            main_ctl_q <= '0;
            skid_ctl_q <= '0;
        end else begin
            main_ctl_q <= main_ctl_d;
            skid_ctl_q <= skid_ctl_d;
        end
    end

    if (DATA_RST_ZERO != 0) begin : g_data_rst
        always_ff @(posedge clock) begin
            if (!nreset) begin
                main_data_q <= '0;
                skid_data_q <= '0;
            end else begin
                main_data_q <= main_data_d;
                skid_data_q <= skid_data_d;
            end
        end
    end else begin : g_data_norst
        // NOTE: payload storage without reset is safe because out_valid gates every use of it.
        always_ff @(posedge clock) begin
            main_data_q <= main_data_d;
            skid_data_q <= skid_data_d;
        end
    end

    assign out_data = main_data_q;
    assign out_ctl  = main_ctl_q & {CTL_W{out_valid}};

`ifdef PIPE_STAGE_PERF_EN
    logic [PIPE_PERF_W-1:0] stall_q, stall_d, bubble_q, bubble_d;

    always_comb begin
        stall_d  = stall_q;
        bubble_d = bubble_q;
        if (out_valid && !out_ready && (stall_q != '1)) stall_d  = stall_q + PIPE_PERF_W'(1);
        if (!out_valid && (bubble_q != '1))             bubble_d = bubble_q + PIPE_PERF_W'(1);
    end

    always_ff @(posedge clock) begin
        if (!nreset) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
        end
    end

    assign stall_cycles  = stall_q;
    assign bubble_cycles = bubble_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: lane 0 builds SKID=1, lane 1 builds SKID=0,
// both driven by the same stimulus and each checked against a FIFO-of-entries model.
module tb_pipe_stage_reg;

    localparam int DW = 32;
    localparam int CW = 16;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } ent_t;

    logic          clock = 1'b0;
    logic          nreset;
    logic          flush;
    logic          in_valid;
    logic          out_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctl;

    logic          ov_w  [2];
    logic          ir_w  [2];
    logic [DW-1:0] od_w  [2];
    logic [CW-1:0] oc_w  [2];
    logic [1:0]    occ_w [2];
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0]   sc_w  [2];
    logic [31:0]   bc_w  [2];
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int SK = (g == 0) ? 1 : 0;

        ent_t        exp_q[$];
        int          cnt      = 0;
        int          cnt_next = 0;
        bit          rdy_exp  = 1'b1;
        bit          rst_edge;
        bit          st_c     = 1'b0;
        bit          bub_c    = 1'b0;
        logic [31:0] p_stall  = '0;
        logic [31:0] p_bubble = '0;

        pipe_stage_reg #(
            .DATA_W(DW), .CTL_W(CW), .SKID(SK), .DATA_RST_ZERO(1)
        ) u_dut (
            .clock    (clock),
            .nreset   (nreset),
            .flush    (flush),
            .in_valid (in_valid),
            .in_ready (ir_w[g]),
            .in_data  (in_data),
            .in_ctl   (in_ctl),
            .out_valid(ov_w[g]),
            .out_ready(out_ready),
            .out_data (od_w[g]),
            .out_ctl  (oc_w[g]),
            .occupancy(occ_w[g])
`ifdef PIPE_STAGE_PERF_EN
            ,
            .stall_cycles (sc_w[g]),
            .bubble_cycles(bc_w[g])
`endif
        );

        // Reference model: a queue of held entries with capacity 2 (SKID) or 1.
        initial forever begin
            @(posedge clock);
            rst_edge = !nreset;
            #1;
            if (rst_edge) begin
                cnt      = 0;
                exp_q.delete();
                p_stall  = '0;
                p_bubble = '0;
            end else begin
                cnt = cnt_next;
                if (st_c  && p_stall  != 32'hFFFF_FFFF) p_stall  = p_stall + 32'd1;
                if (bub_c && p_bubble != 32'hFFFF_FFFF) p_bubble = p_bubble + 32'd1;
            end
            #2;
            rdy_exp = (SK != 0) ? (cnt != 2) : (cnt == 0 || out_ready);
            if (!nreset) begin
                cnt_next = 0;
                st_c     = 1'b0;
                bub_c    = 1'b0;
            end else begin
                st_c  = (cnt > 0) && !out_ready;
                bub_c = (cnt == 0);
                if (flush) begin
                    cnt_next = 0;
                end else begin
                    cnt_next = cnt - int'((cnt > 0) && out_ready) + int'(in_valid && rdy_exp);
                    if (in_valid && rdy_exp) exp_q.push_back({in_data, in_ctl});
                end
            end
        end

        // Monitor: compare presented outputs, retire delivered entries.
        initial forever begin
            @(negedge clock);
            if (nreset) begin
                check($sformatf("L%0d occupancy", g), 64'(occ_w[g]), 64'(cnt));
                check($sformatf("L%0d out_valid", g), 64'(ov_w[g]), 64'(cnt > 0));
                check($sformatf("L%0d in_ready", g), 64'(ir_w[g]), 64'(rdy_exp));
                if (cnt > 0) begin
                    if (exp_q.size() == 0) begin
                        check($sformatf("L%0d scoreboard_underflow", g), 64'(1), 64'(0));
                    end else begin
                        check($sformatf("L%0d out_data", g), 64'(od_w[g]), 64'(exp_q[0].d));
                        check($sformatf("L%0d out_ctl", g), 64'(oc_w[g]), 64'(exp_q[0].c));
                        if (out_ready) void'(exp_q.pop_front());
                    end
                end else begin
                    check($sformatf("L%0d out_ctl_bubble", g), 64'(oc_w[g]), 64'(0));
                end
                if (flush) exp_q.delete();
`ifdef PIPE_STAGE_PERF_EN
                check($sformatf("L%0d stall_cycles", g), 64'(sc_w[g]), 64'(p_stall));
                check($sformatf("L%0d bubble_cycles", g), 64'(bc_w[g]), 64'(p_bubble));
`endif
            end
        end
    end

    task automatic drive(input bit v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                         input bit f, input bit r);
        @(posedge clock);
        #2;
        in_valid  = v;
        in_data   = d;
        in_ctl    = c;
        flush     = f;
        out_ready = r;
    endtask

    initial begin
        nreset    = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_ctl    = 16'hFFFF;
        in_data   = 32'hA5A5_0001;
        out_ready = 1'b1;

        // Reset must win over a valid input carrying all-ones control.
        repeat (3) @(posedge clock);
        @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("L%0d rst out_valid", i), 64'(ov_w[i]), 64'(0));
            check($sformatf("L%0d rst out_ctl", i), 64'(oc_w[i]), 64'(0));
            check($sformatf("L%0d rst occupancy", i), 64'(occ_w[i]), 64'(0));
            check($sformatf("L%0d rst in_ready", i), 64'(ir_w[i]), 64'(1));
            check($sformatf("L%0d rst out_data", i), 64'(od_w[i]), 64'(0));
`ifdef PIPE_STAGE_PERF_EN
            check($sformatf("L%0d rst stall", i), 64'(sc_w[i]), 64'(0));
            check($sformatf("L%0d rst bubble", i), 64'(bc_w[i]), 64'(0));
`endif
        end
        @(posedge clock);
        #2;
        nreset = 1'b1;

        // Streaming at full rate.
        for (int i = 1; i <= 4; i++) drive(1'b1, DW'(i), CW'(16'h0100 + i), 1'b0, 1'b1);
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        drive(1'b0, '0, '0, 1'b0, 1'b1);

        // Fill under stall (A, B), C held off, then drain in order.
        drive(1'b1, 32'hAAAA_0000, 16'h000A, 1'b0, 1'b0);
        drive(1'b1, 32'hBBBB_0000, 16'h000B, 1'b0, 1'b0);
        drive(1'b1, 32'hCCCC_0000, 16'h000C, 1'b0, 1'b0);
        drive(1'b1, 32'hCCCC_0000, 16'h000C, 1'b0, 1'b0);
        drive(1'b1, 32'hCCCC_0000, 16'h000C, 1'b0, 1'b1);
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        drive(1'b0, '0, '0, 1'b0, 1'b1);

        // Flush while full with an input offered in the same cycle.
        drive(1'b1, 32'h1111_0000, 16'h0011, 1'b0, 1'b0);
        drive(1'b1, 32'h2222_0000, 16'h0022, 1'b0, 1'b0);
        drive(1'b1, 32'h3333_0000, 16'h0033, 1'b1, 1'b0);
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b0, 1'b1);

        // Single-entry replacement: stalled, then release with a new input.
        drive(1'b1, 32'h4444_0000, 16'h0044, 1'b0, 1'b0);
        drive(1'b1, 32'h5555_0000, 16'h0055, 1'b0, 1'b0);
        drive(1'b1, 32'h6666_0000, 16'h0066, 1'b0, 1'b1);
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        drive(1'b0, '0, '0, 1'b0, 1'b1);

        // One entry held through 5 stall cycles, then 3 empty cycles.
        drive(1'b1, 32'h7777_0000, 16'h0077, 1'b0, 1'b0);
        repeat (5) drive(1'b0, '0, '0, 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        repeat (3) drive(1'b0, '0, '0, 1'b0, 1'b1);

        // Randomised traffic with occasional flushes and backpressure.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 3) != 0), DW'($urandom), CW'($urandom),
                  ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0));
        end
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        drive(1'b0, '0, '0, 1'b0, 1'b1);

`ifdef PIPE_STAGE_PERF_EN
        // Saturation: preload lane 0's stall counter just below max and keep stalling.
        drive(1'b1, 32'h8888_0000, 16'h0088, 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        force lane[0].u_dut.stall_q = 32'hFFFF_FFFD;
        lane[0].p_stall = 32'hFFFF_FFFD;
        #1;
        release lane[0].u_dut.stall_q;
        repeat (5) drive(1'b0, '0, '0, 1'b0, 1'b0);
        @(negedge clock);
        check("L0 stall_saturated", 64'(sc_w[0]), 64'(32'hFFFF_FFFF));
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        drive(1'b0, '0, '0, 1'b0, 1'b1);
`endif

        @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
